axil_reg_slave: RTL and testbench
=================================

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 The block SHALL have parameter NUM_REGS, default 8, number of 32-bit registers; it SHALL be a power of two, 2..256.
REQ-004 The block SHALL have the following ports, one per line as name, direction, width, meaning:
  ACLK  in  1  clock; all logic is on the rising edge.
  ARESET  in  1  synchronous active-high reset.
  AWVALID/AWREADY  in/out  1/1  write-address handshake.
  AWADDR  in  ADDR_WIDTH  write byte address.
  AWPROT  in  3  accepted, ignored.
  WVALID/WREADY  in/out  1/1  write-data handshake.
  WDATA  in  32  write data.
  WSTRB  in  4  byte enables.
  BVALID/BREADY  out/in  1/1  write-response handshake.
  BRESP  out  2  write response.
  ARVALID/ARREADY  in/out  1/1  read-address handshake.
  ARADDR  in  ADDR_WIDTH  read byte address.
  ARPROT  in  3  accepted, ignored.
  RVALID/RREADY  out/in  1/1  read-data handshake.
  RDATA  out  32  read data.
  RRESP  out  2  read response.

Function
REQ-005 The block SHALL be the downstream AXI4-Lite slave fed by the interconnect: a bank of NUM_REGS read/write registers.
REQ-006 A handshake SHALL occur on any edge where VALID and READY are both 1.
REQ-007 Decode: index = ADDR[log2(NUM_REGS)+1:2]; ADDR[1:0] is ignored. An address >= NUM_REGS*4 is out of range.
REQ-008 The write FSM SHALL have three states:
  - W_IDLE: collect AW and W.
  - W_COMMIT: perform the write.
  - W_RESP: BVALID=1.
REQ-009 In W_IDLE, AWREADY SHALL equal NOT aw_held and WREADY SHALL equal NOT w_held. AW and W may arrive in either order or together; each is latched on its handshake.
REQ-010 The FSM SHALL go from W_IDLE to W_COMMIT on the edge where both aw_held and w_held become (or are) set. A simultaneous AW+W handshake at edge N SHALL give the commit at edge N+1 and BVALID=1 after N+1.
REQ-011 In W_COMMIT, each byte k with WSTRB[k]=1 SHALL be updated. WSTRB=0 SHALL be legal and return OKAY with no change. An out-of-range address SHALL write nothing and return SLVERR (2'b10).
REQ-012 W_RESP SHALL hold BVALID and BRESP stable until BREADY. On the BREADY handshake the FSM SHALL clear both held flags and return to W_IDLE.
REQ-013 AWREADY and WREADY SHALL be 0 in W_COMMIT and W_RESP; back-to-back writes SHALL therefore take at least 3 cycles each.
REQ-014 The read path SHALL have two states:
  - R_IDLE: ARREADY=1.
  - R_DATA: RVALID=1, ARREADY=0.
REQ-015 The AR handshake at edge N SHALL register RDATA/RRESP; RVALID=1 after edge N (1-cycle latency).
REQ-016 RDATA/RRESP SHALL be held until the RREADY handshake, then the read path SHALL return to R_IDLE.
REQ-017 An out-of-range read SHALL return RDATA=0, RRESP=SLVERR; an in-range read SHALL return RRESP=OKAY (2'b00).
REQ-018 When a read capture and a write commit to the same register occur on the same edge, the read SHALL return the pre-write value.
REQ-019 The read and write paths SHALL be fully independent and concurrent.

Reset
REQ-020 ARESET=1 at an edge SHALL clear all registers, FSMs (to W_IDLE/R_IDLE) and held flags, and SHALL set BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
REQ-021 While ARESET=1, AWREADY, WREADY and ARREADY SHALL be 0.
REQ-022 Reset mid-transaction SHALL abandon it with no write and no response; the readies SHALL be 1 on the first cycle after release.

Configuration
REQ-023 With AXIL_REG_RO_ID_EN defined:
  - register 0 is a read-only constant ID_VALUE = 32'hA11E_0001, including during and after reset;
  - writes to index 0 change nothing and return SLVERR.
REQ-024 Without AXIL_REG_RO_ID_EN, register 0 SHALL be an ordinary read/write register resetting to 0.

Structure
REQ-025 A shared package axil_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, ID_VALUE, and the write/read state enums.
REQ-026 Storage with byte-enable write and combinational read SHALL be one sub-module, axil_reg_bank. The handshake FSMs SHALL stay in axil_reg_slave.

Verification
REQ-027 AW+W same cycle, addr 0x04, data 0xDEADBEEF, strb 0xF, BREADY=1 -> BVALID 2 cycles later with OKAY; a read of 0x04 then returns 0xDEADBEEF, OKAY, with RVALID 1 cycle after the AR handshake.
REQ-028 W three cycles before AW, addr 0x08, data 0x11223344, strb 0x5 over an existing 0xAABBCCDD -> BRESP OKAY; a read of 0x08 returns 0xAA22CC44.
REQ-029 Write to 0x40 with NUM_REGS=8 -> BRESP SLVERR, no register changed; a read of 0x40 returns 0, SLVERR.
REQ-030 BREADY=0 for 5 cycles, then a second AW offered -> BVALID/BRESP stable and AWREADY=0 throughout; the second write is accepted only after the B handshake. RREADY held low gives the equivalent result on R.
REQ-031 ARESET pulsed after the AW handshake and before W -> no BVALID, registers=0; the readies are 1 on the cycle after release.
REQ-032 With AXIL_REG_RO_ID_EN: a write of 0x0 to 0x00 -> SLVERR; a read returns 0xA11E0001. Without the macro, the same write is OKAY and the read returns 0.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite register slave.
// AXIL_REG_RO_ID_EN makes register 0 a read-only ID constant.
package axil_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] ID_VALUE    = 32'hA11E_0001;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle with master and slave views.
// Clock and reset are carried as plain ports, not in the bundle.
interface axil_reg_slave_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [2:0]            AWPROT;
    logic                  WVALID;
    logic                  WREADY;
    logic [31:0]           WDATA;
    logic [3:0]            WSTRB;
    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [2:0]            ARPROT;
    logic                  RVALID;
    logic                  RREADY;
    logic [31:0]           RDATA;
    logic [1:0]            RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT,
        output WVALID, WDATA, WSTRB,
        output BREADY,
        output ARVALID, ARADDR, ARPROT,
        output RREADY,
        input  AWREADY, WREADY,
        input  BVALID, BRESP,
        input  ARREADY,
        input  RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT,
        input  WVALID, WDATA, WSTRB,
        input  BREADY,
        input  ARVALID, ARADDR, ARPROT,
        input  RREADY,
        output AWREADY, WREADY,
        output BVALID, BRESP,
        output ARREADY,
        output RVALID, RDATA, RRESP
    );

endinterface

// File: rtl/axil_reg_bank.sv
// Register storage: byte-enable write, combinational read.
// AXIL_REG_RO_ID_EN overrides index 0 reads with ID_VALUE.
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb[k]) begin
                    mem[widx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = mem[ridx];
`ifdef AXIL_REG_RO_ID_EN
        if (ridx == '0) begin
            rdata = ID_VALUE;
        end
`endif
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave over a bank of NUM_REGS 32-bit registers.
// Define AXIL_REG_RO_ID_EN for a read-only ID at register 0.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    axil_reg_slave_if.slave   s
);

    localparam int IDX_W = $clog2(NUM_REGS);

    if (DATA_WIDTH != 32) begin : g_bad_dw
        $error("axil_reg_slave: DATA_WIDTH must be 32");
    end
    if (NUM_REGS < 2 || NUM_REGS > 256 || (1 << IDX_W) != NUM_REGS) begin : g_bad_nr
        $error("axil_reg_slave: NUM_REGS must be a power of two in 2..256");
    end

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (IDX_W + 2)) == '0;
    endfunction

    w_state_e w_state, w_next;
    r_state_e r_state, r_next;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic [1:0]            bresp;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic commit, wr_ok, bank_we;
    logic [31:0] bank_rdata;

    // Readies are forced low while reset is asserted.
    assign s.AWREADY = (w_state == W_IDLE) && !aw_held && !ARESET;
    assign s.WREADY  = (w_state == W_IDLE) && !w_held && !ARESET;
    assign s.BVALID  = (w_state == W_RESP);
    assign s.BRESP   = bresp;
    assign s.ARREADY = (r_state == R_IDLE) && !ARESET;
    assign s.RVALID  = (r_state == R_DATA);
    assign s.RDATA   = rdata;
    assign s.RRESP   = rresp;

    assign aw_fire = s.AWVALID && s.AWREADY;
    assign w_fire  = s.WVALID && s.WREADY;
    assign b_fire  = s.BVALID && s.BREADY;
    assign ar_fire = s.ARVALID && s.ARREADY;
    assign r_fire  = s.RVALID && s.RREADY;

    assign commit = (w_state == W_COMMIT);

`ifdef AXIL_REG_RO_ID_EN
    assign wr_ok = in_range(aw_addr) && (aw_addr[IDX_W+1:2] != '0);
`else
    assign wr_ok = in_range(aw_addr);
`endif
    assign bank_we = commit && wr_ok;

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: begin
                if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                    w_next = W_COMMIT;
                end
            end
            W_COMMIT: w_next = W_RESP;
            W_RESP: begin
                if (s.BREADY) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_addr <= s.AWADDR;
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= s.WDATA;
                w_strb <= s.WSTRB;
            end
            if (commit) begin
                bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (b_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (ar_fire) r_next = R_DATA;
            R_DATA: if (r_fire) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Bank read is combinational, so a same-edge commit yields old data.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (ar_fire) begin
                rdata <= in_range(s.ARADDR) ? bank_rdata : '0;
                rresp <= in_range(s.ARADDR) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    axil_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk   (ACLK),
        .rst   (ARESET),
        .we    (bank_we),
        .widx  (aw_addr[IDX_W+1:2]),
        .wdata (w_data),
        .wstrb (w_strb),
        .ridx  (s.ARADDR[IDX_W+1:2]),
        .rdata (bank_rdata)
    );

    logic unused_ok;
    assign unused_ok = ^{s.AWPROT, s.ARPROT, s.ARADDR[1:0], aw_addr[1:0]};

endmodule

// File: tb/tb_axil_reg_slave.sv
// Scoreboard bench for axil_reg_slave: expected B/R responses are
// queued at issue time from a reference register model.
module tb_axil_reg_slave;
    import axil_pkg::*;

    localparam int NREGS = 8;
    localparam int IW    = $clog2(NREGS);
    localparam int TMO   = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_reg_slave_if #(.ADDR_WIDTH(32)) bus ();

    axil_reg_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (NREGS)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .s      (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model [NREGS];
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];

    task automatic check(input string tag, input logic [33:0] got,
                         input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return a < NREGS * 4;
    endfunction

    function automatic logic ro_hit(input logic [31:0] a);
`ifdef AXIL_REG_RO_ID_EN
        return in_rng(a) && (a[IW+1:2] == '0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [33:0] exp_read(input logic [31:0] a);
        if (!in_rng(a)) return {RESP_SLVERR, 32'h0};
        if (ro_hit(a)) return {RESP_OKAY, ID_VALUE};
        return {RESP_OKAY, model[a[IW+1:2]]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] st);
        if (in_rng(a) && !ro_hit(a)) begin
            for (int k = 0; k < 4; k++) begin
                if (st[k]) model[a[IW+1:2]][8*k +: 8] = d[8*k +: 8];
            end
            b_q.push_back(RESP_OKAY);
        end else begin
            b_q.push_back(RESP_SLVERR);
        end
    endtask

    task automatic drive_aw(input logic [31:0] a);
        int n = 0;
        bus.AWVALID = 1'b1;
        bus.AWADDR  = a;
        while (!bus.AWREADY && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) check("aw_timeout", 0, 1);
        @(negedge clk);
        bus.AWVALID = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] st);
        int n = 0;
        bus.WVALID = 1'b1;
        bus.WDATA  = d;
        bus.WSTRB  = st;
        while (!bus.WREADY && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) check("w_timeout", 0, 1);
        @(negedge clk);
        bus.WVALID = 1'b0;
    endtask

    task automatic drive_aw_w(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] st);
        int n = 0;
        bus.AWVALID = 1'b1;
        bus.AWADDR  = a;
        bus.WVALID  = 1'b1;
        bus.WDATA   = d;
        bus.WSTRB   = st;
        while (!(bus.AWREADY && bus.WREADY) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) check("aww_timeout", 0, 1);
        @(negedge clk);
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
    endtask

    task automatic wait_b(input int hold);
        int n = 0;
        logic [1:0] exp;
        bus.BREADY = 1'b0;
        while (!bus.BVALID && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            check("b_timeout", 0, 1);
            return;
        end
        if (b_q.size() == 0) begin
            check("b_unexpected", 1, 0);
            exp = 2'b00;
        end else begin
            exp = b_q.pop_front();
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("b_hold_valid", bus.BVALID, 1);
            check("b_hold_resp", bus.BRESP, exp);
            check("b_hold_awready", bus.AWREADY, 0);
        end
        check("bresp", bus.BRESP, exp);
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        check("b_drop", bus.BVALID, 0);
    endtask

    task automatic axil_write(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] st, input int w_lead);
        model_write(a, d, st);
        if (w_lead == 0) begin
            drive_aw_w(a, d, st);
        end else begin
            drive_w(d, st);
            repeat (w_lead - 1) @(negedge clk);
            drive_aw(a);
        end
        wait_b(0);
    endtask

    task automatic finish_r(input int hold, input logic [31:0] a);
        logic [33:0] exp;
        check("r_latency", bus.RVALID, 1);
        if (r_q.size() == 0) begin
            check("r_unexpected", 1, 0);
            exp = '0;
        end else begin
            exp = r_q.pop_front();
        end
        for (int i = 0; i < hold; i++) begin
            bus.ARVALID = 1'b1;
            bus.ARADDR  = a ^ 32'h4;
            @(negedge clk);
            check("r_hold_valid", bus.RVALID, 1);
            check("r_hold_data", {bus.RRESP, bus.RDATA}, exp);
            check("r_hold_arready", bus.ARREADY, 0);
        end
        bus.ARVALID = 1'b0;
        check("rdata", {bus.RRESP, bus.RDATA}, exp);
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
        check("r_drop", bus.RVALID, 0);
    endtask

    task automatic axil_read(input logic [31:0] a, input int hold);
        int n = 0;
        r_q.push_back(exp_read(a));
        bus.ARVALID = 1'b1;
        bus.ARADDR  = a;
        while (!bus.ARREADY && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) check("ar_timeout", 0, 1);
        @(negedge clk);
        bus.ARVALID = 1'b0;
        finish_r(hold, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        bus.AWVALID = 0; bus.AWADDR = '0; bus.AWPROT = 3'd0;
        bus.WVALID  = 0; bus.WDATA  = '0; bus.WSTRB  = 4'd0;
        bus.BREADY  = 0;
        bus.ARVALID = 0; bus.ARADDR = '0; bus.ARPROT = 3'd0;
        bus.RREADY  = 0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_awready", bus.AWREADY, 0);
        check("rst_wready", bus.WREADY, 0);
        check("rst_arready", bus.ARREADY, 0);
        check("rst_bvalid", bus.BVALID, 0);
        check("rst_rvalid", bus.RVALID, 0);
        check("rst_rdata", {bus.RRESP, bus.RDATA}, 0);
        check("rst_bresp", bus.BRESP, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_awready", bus.AWREADY, 1);
        check("rel_arready", bus.ARREADY, 1);

        // AW+W together; BVALID two edges after the handshake
        model_write(32'h04, 32'hDEADBEEF, 4'hF);
        drive_aw_w(32'h04, 32'hDEADBEEF, 4'hF);
        check("b_early", bus.BVALID, 0);
        @(negedge clk);
        check("b_latency", bus.BVALID, 1);
        wait_b(0);
        axil_read(32'h04, 0);
        axil_read(32'h05, 0);

        // W leads AW by three cycles, partial strobes
        axil_write(32'h08, 32'hAABBCCDD, 4'hF, 0);
        axil_write(32'h08, 32'h11223344, 4'h5, 3);
        axil_read(32'h08, 0);
        axil_write(32'h08, 32'h99999999, 4'h0, 1);
        axil_read(32'h08, 0);

        // out of range
        axil_write(32'h40, 32'h12345678, 4'hF, 0);
        axil_read(32'h40, 0);
        axil_read(32'h04, 0);
        axil_read(32'h1C, 0);

        // BREADY held low while a second AW is offered
        model_write(32'h0C, 32'h0C0C0C0C, 4'hF);
        drive_aw_w(32'h0C, 32'h0C0C0C0C, 4'hF);
        model_write(32'h10, 32'h10101010, 4'hF);
        bus.AWVALID = 1'b1;
        bus.AWADDR  = 32'h10;
        wait_b(5);
        check("aw2_ready", bus.AWREADY, 1);
        @(negedge clk);
        bus.AWVALID = 1'b0;
        drive_w(32'h10101010, 4'hF);
        wait_b(0);
        axil_read(32'h0C, 5);
        axil_read(32'h10, 0);

        // read capture on the same edge as a write commit
        axil_write(32'h14, 32'h55555555, 4'hF, 0);
        old = model[5];
        model_write(32'h14, 32'h66666666, 4'hF);
        r_q.push_back({RESP_OKAY, old});
        drive_aw_w(32'h14, 32'h66666666, 4'hF);
        bus.ARVALID = 1'b1;
        bus.ARADDR  = 32'h14;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        finish_r(0, 32'h14);
        wait_b(0);
        axil_read(32'h14, 0);

        // register 0
        axil_write(32'h00, 32'h0, 4'hF, 0);
        axil_read(32'h00, 0);
        axil_write(32'h00, 32'hCAFEF00D, 4'hF, 0);
        axil_read(32'h00, 0);

        // reset between AW and W
        drive_aw(32'h04);
        rst = 1'b1;
        @(negedge clk);
        check("mid_awready", bus.AWREADY, 0);
        check("mid_wready", bus.WREADY, 0);
        check("mid_arready", bus.ARREADY, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        @(negedge clk);
        check("post_awready", bus.AWREADY, 1);
        check("post_wready", bus.WREADY, 1);
        check("post_arready", bus.ARREADY, 1);
        check("post_rdata", {bus.RRESP, bus.RDATA}, 0);
        repeat (3) begin
            @(negedge clk);
            check("post_bvalid", bus.BVALID, 0);
        end
        axil_read(32'h04, 0);
        axil_read(32'h08, 0);
        axil_read(32'h00, 0);

        check("b_q_empty", b_q.size(), 0);
        check("r_q_empty", r_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
